fir_output_capture: RTL and testbench

- Sink for the n_tap_fir output stream (signed, 2*DATA_WIDTH wide).
- After a start pulse, it discards the FIR pipeline-latency samples, then stores CAPTURE_LEN consecutive samples in an internal buffer.
- It then streams the stored samples out one per enabled read cycle, for host or MATLAB comparison.
- Sits directly on dut.dataOut in filter benches and in the pulse-compression top level.

---
 rtl/fir_capture_pkg.sv | 24 ++
 rtl/capture_ram.sv | 31 +++
 rtl/fir_output_capture.sv | 153 +++++++++++++++
 tb/tb_fir_output_capture.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_capture_pkg.sv
// Shared types and defaults for the FIR output capture sink.
// Defaults match the n_tap_fir filter benches.
package fir_capture_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_LENGTH      = 20;
  localparam int DEF_SKIP_CYCLES = 1;
  localparam int DEF_DATA_LEN    = 33;
  localparam int DEF_CAPTURE_LEN = DEF_DATA_LEN + DEF_LENGTH - 1;
  localparam int DEF_ADDR_WIDTH  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CAPTURE,
    ST_READY,
    ST_READOUT
  } cap_state_e;

  function automatic int sample_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Read register holds its value while re_i is low.
module capture_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_output_capture.sv
// Captures CAPTURE_LEN FIR output samples after a skip window, then replays them.
// Optional peak magnitude tracking under FIR_CAPTURE_PEAK_DETECT_EN.
module fir_output_capture
  import fir_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LENGTH      = DEF_LENGTH,
  parameter int SKIP_CYCLES = (LENGTH > 0) ? DEF_SKIP_CYCLES : 0,
  parameter int CAPTURE_LEN = DEF_CAPTURE_LEN,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         startFlag,
  input  logic signed [2*DATA_WIDTH-1:0] dataIn,
  input  logic                         readEnable,
  output logic signed [2*DATA_WIDTH-1:0] dataOut,
  output logic                         dataValid,
  output logic                         captureDone,
  output logic                         busy
`ifdef FIR_CAPTURE_PEAK_DETECT_EN
  ,
  output logic [2*DATA_WIDTH-1:0]      peakValue,
  output logic [ADDR_WIDTH-1:0]        peakIndex
`endif
);

  localparam int SW = sample_width(DATA_WIDTH);
  localparam int SKW = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
  localparam int SKIP_LAST = (SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPTURE_LEN - 1);

  cap_state_e state_q, state_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic valid_q;
  logic we, re;
  logic [SW-1:0] rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= re;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (startFlag) begin
          skip_d  = '0;
          wr_d    = '0;
          state_d = (SKIP_CYCLES == 0) ? ST_CAPTURE : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (skip_q == SKW'(SKIP_LAST)) state_d = ST_CAPTURE;
        else skip_d = skip_q + 1'b1;
      end
      ST_CAPTURE: begin
        we   = 1'b1;
        wr_d = wr_q + 1'b1;
        if (wr_q == ADDR_LAST) begin
          rd_d    = '0;
          state_d = ST_READY;
        end
      end
      ST_READY, ST_READOUT: begin
        if (readEnable) begin
          re      = 1'b1;
          rd_d    = rd_q + 1'b1;
          state_d = (rd_q == ADDR_LAST) ? ST_IDLE : ST_READOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
    captureDone = (state_q == ST_READY) || (state_q == ST_READOUT);
    dataValid   = valid_q;
    dataOut     = rdata;
  end

  capture_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(SW)
  ) u_ram (
    .clk_i  (clock),
    .rst_n_i(reset_n),
    .we_i   (we),
    .waddr_i(wr_q),
    .wdata_i(dataIn),
    .re_i   (re),
    .raddr_i(rd_q),
    .rdata_o(rdata)
  );

`ifdef FIR_CAPTURE_PEAK_DETECT_EN
  logic [SW-1:0] peak_q, peak_d, mag;
  logic [ADDR_WIDTH-1:0] pidx_q, pidx_d;

  // Most negative input has no positive twin; clamp to max positive.
  always_comb begin
    if (!dataIn[SW-1])
      mag = $unsigned(dataIn);
    else if (dataIn == {1'b1, {(SW-1){1'b0}}})
      mag = {1'b0, {(SW-1){1'b1}}};
    else
      mag = $unsigned(-dataIn);
    peak_d = peak_q;
    pidx_d = pidx_q;
    if (state_d == ST_CAPTURE && state_q != ST_CAPTURE) begin
      peak_d = '0;
      pidx_d = '0;
    end else if (we && mag > peak_q) begin
      peak_d = mag;
      pidx_d = wr_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
      pidx_q <= '0;
    end else begin
      peak_q <= peak_d;
      pidx_q <= pidx_d;
    end
  end

  assign peakValue = peak_q;
  assign peakIndex = pidx_q;
`endif

endmodule

// File: tb/tb_fir_output_capture.sv
// Directed bench for fir_output_capture with default parameters.
// Peak checks are compiled in with FIR_CAPTURE_PEAK_DETECT_EN.
module tb_fir_output_capture;

  localparam int N = 52;

  logic clk;
  logic reset_n;
  logic startFlag;
  logic signed [15:0] dataIn;
  logic readEnable;
  logic signed [15:0] dataOut;
  logic dataValid;
  logic captureDone;
  logic busy;
`ifdef FIR_CAPTURE_PEAK_DETECT_EN
  logic [15:0] peakValue;
  logic [5:0] peakIndex;
`endif

  int n_chk;
  int n_fail;
  logic signed [15:0] smp [N];

  fir_output_capture dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .startFlag  (startFlag),
    .dataIn     (dataIn),
    .readEnable (readEnable),
    .dataOut    (dataOut),
    .dataValid  (dataValid),
    .captureDone(captureDone),
`ifdef FIR_CAPTURE_PEAK_DETECT_EN
    .peakValue  (peakValue),
    .peakIndex  (peakIndex),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start, skip one sample, then feed smp[]; optional startFlag poke mid-capture.
  task automatic run_capture(input int poke_at);
    startFlag  = 1'b1;
    readEnable = 1'b0;
    tick();
    startFlag = 1'b0;
    dataIn    = 16'sh5a5a;
    tick();
    for (int i = 0; i < N; i++) begin
      dataIn    = smp[i];
      startFlag = (i == poke_at);
      tick();
    end
    startFlag = 1'b0;
    check("cap_done", captureDone, 1);
    check("cap_busy", busy, 0);
  endtask

  task automatic read_back(input bit paused, input bit poke_start);
    int issued = 0;
    bit re_prev;
    logic signed [15:0] last = smp[0];
    for (int c = 0; c < 400 && issued < N; c++) begin
      readEnable = paused ? (c % 3 == 0) : 1'b1;
      startFlag  = poke_start && (c == 4 || c == 5);
      re_prev    = readEnable;
      tick();
      if (re_prev) begin
        check("rd_valid", dataValid, 1);
        check("rd_data", dataOut, smp[issued]);
        last = smp[issued];
        issued++;
      end else begin
        check("rd_gap_valid", dataValid, 0);
        check("rd_gap_hold", dataOut, last);
      end
      check("rd_done", captureDone, issued < N);
    end
    readEnable = 1'b0;
    startFlag  = 1'b0;
    check("rd_count", issued, N);
    tick();
    check("rd_after_valid", dataValid, 0);
    check("rd_after_busy", busy, 0);
  endtask

  initial begin
    int nval;
    int nbusy;
    n_chk      = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    startFlag  = 1'b0;
    readEnable = 1'b0;
    dataIn     = '0;
    #25;
    check("rst_dout", dataOut, 0);
    check("rst_valid", dataValid, 0);
    check("rst_done", captureDone, 0);
    check("rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // readEnable in IDLE does nothing
    readEnable = 1'b1;
    tick();
    tick();
    check("idle_re_valid", dataValid, 0);
    check("idle_re_busy", busy, 0);
    check("idle_re_done", captureDone, 0);

    // Ramp: dataIn counts from 0 starting after the start edge
    startFlag = 1'b1;
    dataIn    = 16'sd0;
    tick();
    startFlag = 1'b0;
    nval  = 0;
    nbusy = 0;
    for (int c = 0; c < 300 && nval < N; c++) begin
      if (busy) nbusy++;
      if (dataValid) begin
        check("ramp_data", dataOut, nval + 1);
        check("ramp_done", captureDone, nval != N - 1);
        nval++;
      end
      dataIn = 16'(c);
      tick();
    end
    check("ramp_count", nval, N);
    check("ramp_busy", nbusy, N + 1);
    readEnable = 1'b0;
    tick();
    check("ramp_tail_valid", dataValid, 0);

    // Signed extremes, continuous read, startFlag poked in CAPTURE and READOUT
    for (int i = 0; i < N; i++) smp[i] = 16'(i * 3);
    smp[0] = -16'sd32768;
    smp[1] = 16'sd32767;
    smp[2] = -16'sd1;
    smp[3] = 16'sd0;
    run_capture(10);
    read_back(1'b0, 1'b1);

    // Paused readout pattern 1,0,0
    for (int i = 0; i < N; i++) smp[i] = 16'(100 - 7 * i);
    run_capture(-1);
    read_back(1'b1, 1'b0);

    // Reset mid-capture at sample 20
    startFlag = 1'b1;
    tick();
    startFlag = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      dataIn = 16'(500 + i);
      tick();
    end
    check("mid_busy", busy, 1);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_dout", dataOut, 0);
    check("mid_rst_valid", dataValid, 0);
    check("mid_rst_done", captureDone, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_done", captureDone, 0);
    check("post_rst_busy", busy, 0);
    for (int i = 0; i < N; i++) smp[i] = 16'(1000 + i);
    run_capture(-1);
    read_back(1'b0, 1'b0);

`ifdef FIR_CAPTURE_PEAK_DETECT_EN
    for (int i = 0; i < N; i++) smp[i] = 16'sd0;
    smp[0] = 16'sd5;
    smp[1] = -16'sd300;
    smp[2] = 16'sd300;
    smp[3] = 16'sd12;
    run_capture(-1);
    check("peak_val", peakValue, 300);
    check("peak_idx", peakIndex, 1);
    read_back(1'b0, 1'b0);
    smp[30] = -16'sd32768;
    run_capture(-1);
    check("peak_sat_val", peakValue, 32767);
    check("peak_sat_idx", peakIndex, 30);
    read_back(1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
